// File: rtl/coin_frontend_pkg.sv
// Shared encodings and constants for the coin/button input front end.
package coin_frontend_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCoinHeld = 2'd1,
    StJam      = 2'd2
  } coin_state_e;

  // Credit units, in multiples of 50.
  localparam int unsigned UNIT50  = 1;
  localparam int unsigned UNIT100 = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned JAM_CYCLES_DEF      = 64;

endpackage

// File: rtl/sync_debounce_edge.sv
// Two-flop synchronizer, counting debouncer and rising-edge flag for one raw level.
module sync_debounce_edge
  import coin_frontend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances on disagreeing samples; any agreeing sample restarts it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/coin_input_frontend.sv
// Coin/button conditioning ahead of the coffee controller: clean pulses, rejects, jam detect.
// Optional credit audit counter (coin_total) enabled by defining COIN_AUDIT_EN.
module coin_input_frontend
  import coin_frontend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned JAM_CYCLES      = JAM_CYCLES_DEF,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin50_raw,
  input  logic        coin100_raw,
  input  logic        coff_btn_raw,
  input  logic        ret_btn_raw,
  input  logic        inhibit,
  input  logic        jam_clr,
  output logic        fifty,
  output logic        hundred,
  output logic        coff_out_req,
  output logic        coin_ret_req,
  output logic        coin_reject,
  output logic        jam
`ifdef COIN_AUDIT_EN
  ,
  output logic [15:0] coin_total
`endif
);

  logic c50_lvl, c50_rise, c100_lvl, c100_rise;
  logic coff_lvl, coff_rise, ret_lvl, ret_rise;

  sync_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_c50 (
    .clk_i(clk), .reset_i(reset), .raw_i(coin50_raw), .level_o(c50_lvl), .rise_o(c50_rise)
  );
  sync_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_c100 (
    .clk_i(clk), .reset_i(reset), .raw_i(coin100_raw), .level_o(c100_lvl), .rise_o(c100_rise)
  );
  sync_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_coff (
    .clk_i(clk), .reset_i(reset), .raw_i(coff_btn_raw), .level_o(coff_lvl), .rise_o(coff_rise)
  );
  sync_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ret (
    .clk_i(clk), .reset_i(reset), .raw_i(ret_btn_raw), .level_o(ret_lvl), .rise_o(ret_rise)
  );

  // Buttons are edge-only; their debounced levels have no consumer.
  logic unused_btn_lvl;
  assign unused_btn_lvl = coff_lvl ^ ret_lvl;

  coin_state_e      state_q, state_d;
  logic [CNT_W-1:0] jam_cnt_q, jam_cnt_d;
  logic             fifty_q, fifty_d, hundred_q, hundred_d;
  logic             coff_q, coff_d, ret_q, ret_d;
  logic             reject_q, reject_d, jam_q, jam_d;
  logic             coff_pend_q, coff_pend_d, ret_pend_q, ret_pend_d;
  logic             any_lvl;

  assign any_lvl = c50_lvl | c100_lvl;

  // Coin FSM next state.
  always_comb begin
    state_d   = state_q;
    jam_cnt_d = jam_cnt_q;
    unique case (state_q)
      StIdle: begin
        jam_cnt_d = '0;
        if (c50_rise || c100_rise) state_d = StCoinHeld;
      end
      StCoinHeld: begin
        if (!any_lvl) begin
          state_d   = StIdle;
          jam_cnt_d = '0;
        end else if (jam_cnt_q == CNT_W'(JAM_CYCLES - 1)) begin
          state_d   = StJam;
          jam_cnt_d = '0;
        end else begin
          jam_cnt_d = jam_cnt_q + 1'b1;
        end
      end
      StJam: begin
        if (jam_clr && !any_lvl) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Coin outputs and button arbitration.
  always_comb begin
    logic coff_req, ret_req;
    fifty_d   = 1'b0;
    hundred_d = 1'b0;
    reject_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c50_rise && c100_rise) begin
          reject_d = 1'b1;
        end else if (c50_rise || c100_rise) begin
          if (inhibit) begin
            reject_d = 1'b1;
          end else begin
            fifty_d   = c50_rise;
            hundred_d = c100_rise;
          end
        end
      end
      StCoinHeld: reject_d = c50_rise | c100_rise;
      default: ;
    endcase
    jam_d    = (state_d == StJam);
    reject_d = reject_d | jam_d;

    // Return wins over coffee; a credit pulse defers both by one cycle.
    ret_req  = ret_rise | ret_pend_q;
    coff_req = (coff_rise | coff_pend_q) & ~ret_req;
    if (fifty_d || hundred_d) begin
      coff_d      = 1'b0;
      ret_d       = 1'b0;
      coff_pend_d = coff_req;
      ret_pend_d  = ret_req;
    end else begin
      coff_d      = coff_req;
      ret_d       = ret_req;
      coff_pend_d = 1'b0;
      ret_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      jam_cnt_q   <= '0;
      fifty_q     <= 1'b0;
      hundred_q   <= 1'b0;
      coff_q      <= 1'b0;
      ret_q       <= 1'b0;
      reject_q    <= 1'b0;
      jam_q       <= 1'b0;
      coff_pend_q <= 1'b0;
      ret_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      jam_cnt_q   <= jam_cnt_d;
      fifty_q     <= fifty_d;
      hundred_q   <= hundred_d;
      coff_q      <= coff_d;
      ret_q       <= ret_d;
      reject_q    <= reject_d;
      jam_q       <= jam_d;
      coff_pend_q <= coff_pend_d;
      ret_pend_q  <= ret_pend_d;
    end
  end

  assign fifty        = fifty_q;
  assign hundred      = hundred_q;
  assign coff_out_req = coff_q;
  assign coin_ret_req = ret_q;
  assign coin_reject  = reject_q;
  assign jam          = jam_q;

`ifdef COIN_AUDIT_EN
  logic [15:0] total_q, total_d;

  // Saturating credit total in units of 50.
  always_comb begin
    total_d = total_q;
    if (fifty_d) begin
      total_d = (total_q > 16'hFFFF - 16'(UNIT50)) ? 16'hFFFF : total_q + 16'(UNIT50);
    end else if (hundred_d) begin
      total_d = (total_q > 16'hFFFF - 16'(UNIT100)) ? 16'hFFFF : total_q + 16'(UNIT100);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign coin_total = total_q;
`endif

endmodule

// File: tb/tb_coin_input_frontend.sv
// Directed, table-driven bench for coin_input_frontend (default build, audit disabled).
module tb_coin_input_frontend;

  logic clk = 1'b0;
  logic reset, coin50_raw, coin100_raw, coff_btn_raw, ret_btn_raw, inhibit, jam_clr;
  logic fifty, hundred, coff_out_req, coin_ret_req, coin_reject, jam;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  coin_input_frontend #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .coin50_raw(coin50_raw), .coin100_raw(coin100_raw),
    .coff_btn_raw(coff_btn_raw), .ret_btn_raw(ret_btn_raw), .inhibit(inhibit),
    .jam_clr(jam_clr), .fifty(fifty), .hundred(hundred), .coff_out_req(coff_out_req),
    .coin_ret_req(coin_ret_req), .coin_reject(coin_reject), .jam(jam)
  );

  // Output vector order: {fifty, hundred, coff_out_req, coin_ret_req, coin_reject, jam}
  typedef struct packed {
    logic [3:0] raw;   // {coin50, coin100, coff_btn, ret_btn}
    logic       inh;
    logic [5:0] exp7;  // expected outputs 7 edges after raw is driven
    logic [5:0] exp8;  // expected outputs one edge later
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {fifty, hundred, coff_out_req, coin_ret_req, coin_reject, jam};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_raw(input logic [3:0] raw);
    {coin50_raw, coin100_raw, coff_btn_raw, ret_btn_raw} = raw;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_raw(4'b0000);
    inhibit = 1'b0;
    jam_clr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 1'b0, 6'b100000, 6'b000000};  // coin50
    vecs[1]  = '{4'b0100, 1'b0, 6'b010000, 6'b000000};  // coin100
    vecs[2]  = '{4'b1100, 1'b0, 6'b000010, 6'b000000};  // both coins together
    vecs[3]  = '{4'b0100, 1'b1, 6'b000010, 6'b000000};  // coin100 inhibited
    vecs[4]  = '{4'b1000, 1'b1, 6'b000010, 6'b000000};  // coin50 inhibited
    vecs[5]  = '{4'b0010, 1'b0, 6'b001000, 6'b000000};  // coffee
    vecs[6]  = '{4'b0001, 1'b0, 6'b000100, 6'b000000};  // return
    vecs[7]  = '{4'b0011, 1'b0, 6'b000100, 6'b000000};  // both buttons: return only
    vecs[8]  = '{4'b1001, 1'b0, 6'b100000, 6'b000100};  // coin50 + return: deferred
    vecs[9]  = '{4'b0110, 1'b0, 6'b010000, 6'b001000};  // coin100 + coffee: deferred
    vecs[10] = '{4'b1011, 1'b0, 6'b100000, 6'b000100};  // coin50 + both buttons
    vecs[11] = '{4'b0000, 1'b0, 6'b000000, 6'b000000};  // idle

    do_reset();
    check_outs("reset_state", 6'b000000);

    for (int i = 0; i < NVEC; i++) begin
      do_reset();
      drive_raw(vecs[i].raw);
      inhibit = vecs[i].inh;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (t == 7)      check_outs($sformatf("vec%0d_t7", i), vecs[i].exp7);
        else if (t == 8) check_outs($sformatf("vec%0d_t8", i), vecs[i].exp8);
        else             check_outs($sformatf("vec%0d_t%0d", i, t), 6'b000000);
      end
    end

    // coin100 bouncing, then steady high.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      coin100_raw = (i % 2 == 0);
      tick();
      check_outs($sformatf("bounce_t%0d", i), 6'b000000);
    end
    coin100_raw = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_outs($sformatf("bounce_steady_t%0d", t), (t == 7) ? 6'b010000 : 6'b000000);
    end

    // Jam detection, buttons while jammed, clear rules, recovery.
    do_reset();
    coin50_raw = 1'b1;
    for (int t = 1; t <= 75; t++) begin
      tick();
      if (t == 7)  check_outs("jam_credit", 6'b100000);
      if (t == 60) check_outs("jam_not_yet", 6'b000000);
    end
    check_outs("jam_set", 6'b000011);
    ret_btn_raw = 1'b1;
    repeat (7) tick();
    check_outs("jam_ret_btn", 6'b000111);
    tick();
    check_outs("jam_ret_btn_once", 6'b000011);
    ret_btn_raw = 1'b0;
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    check_outs("jam_clr_coin_high", 6'b000011);
    coin50_raw = 1'b0;
    repeat (10) tick();
    check_outs("jam_sticky", 6'b000011);
    jam_clr = 1'b1;
    tick();
    jam_clr = 1'b0;
    check_outs("jam_cleared", 6'b000000);
    coin50_raw = 1'b1;
    repeat (7) tick();
    check_outs("post_jam_credit", 6'b100000);
    tick();
    check_outs("post_jam_idle", 6'b000000);

    // Reset while a coffee press is pending behind a coin credit.
    do_reset();
    drive_raw(4'b1010);
    repeat (7) tick();
    check_outs("pend_credit", 6'b100000);
    reset = 1'b1;
    drive_raw(4'b0000);
    tick();
    check_outs("pend_reset", 6'b000000);
    reset = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check_outs($sformatf("pend_after_t%0d", t), 6'b000000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
